counter_load_sched: RTL and testbench

COUNTER_LOAD_SCHED -- requirements
Module: counter_load_sched

---
 rtl/counter_load_sched_pkg.sv | 28 ++
 rtl/counter_load_sched_rr_arbiter.sv | 41 ++++
 rtl/counter_load_sched.sv | 121 ++++++++++++
 tb/tb_counter_load_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/counter_load_sched_pkg.sv
// ============================================================================
// Module   : counter_load_sched_pkg
// Purpose  : Shared constants and FSM encoding for counter_load_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_load_sched_pkg;

   localparam int         CNT_W   = 4;
   localparam logic [3:0] CNT_MAX = 4'hF;
   localparam int         MAX_REQ = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      STATE_IDLE  = ST_IDLE,
      STATE_LOAD  = ST_LOAD,
      STATE_COUNT = ST_COUNT,
      STATE_DONE  = ST_DONE
   } state_t;

endpackage

`default_nettype wire

// File: rtl/counter_load_sched_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick; search starts at i_ptr and wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx
);

   int   w_sel;
   logic w_found;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sel   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel = int'(i_ptr) + i;
         if (w_sel >= NUM_REQ) begin
            w_sel = w_sel - NUM_REQ;
         end
         if (!w_found && i_req[w_sel]) begin
            w_found      = 1'b1;
            o_idx        = IDX_W'(w_sel);
            o_gnt[w_sel] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/counter_load_sched.sv
// ============================================================================
// Module   : counter_load_sched
// Purpose  : Round-robin scheduler sharing one loadable 4-bit up-counter
//            between NUM_REQ requesters. Optional macro
//            COUNTER_LOAD_SCHED_ABORT_EN lets the granted requester abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_load_sched
   import counter_load_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [CNT_W*NUM_REQ-1:0] load_val_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [NUM_REQ-1:0]       done_o,
   output logic                     busy_o,
   output logic [CNT_W-1:0]         count_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     w_ptr_nxt;
   logic [IDX_W-1:0]     w_ptr_adv;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   w_gnt_nxt;
   logic [NUM_REQ-1:0]   w_arb_gnt;
   logic [IDX_W-1:0]     w_arb_idx;
   logic [CNT_W-1:0]     w_load_val;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req (req_i),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx)
   );

   assign w_load_val = load_val_i[int'(r_idx)*CNT_W +: CNT_W];
   assign w_ptr_adv  = (r_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_idx + IDX_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      case (r_state)
         STATE_IDLE: begin
            if (|w_arb_gnt) begin
               w_idx_nxt   = w_arb_idx;
               w_gnt_nxt   = w_arb_gnt;
               w_state_nxt = STATE_LOAD;
            end
         end
         STATE_LOAD: begin
            w_cnt_nxt   = w_load_val;
            w_state_nxt = STATE_COUNT;
         end
         STATE_COUNT: begin
            // Saturate at CNT_MAX: the counter never wraps back to zero.
            if (r_cnt == CNT_MAX) begin
               w_state_nxt = STATE_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         STATE_DONE: begin
            w_ptr_nxt   = w_ptr_adv;
            w_state_nxt = STATE_IDLE;
         end
         default: begin
            w_state_nxt = STATE_IDLE;
         end
      endcase
`ifdef COUNTER_LOAD_SCHED_ABORT_EN
      if (((r_state == STATE_LOAD) || (r_state == STATE_COUNT)) && !req_i[r_idx]) begin
         w_cnt_nxt   = r_cnt;
         w_ptr_nxt   = w_ptr_adv;
         w_state_nxt = STATE_IDLE;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= STATE_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
      end
   end

   assign busy_o  = (r_state != STATE_IDLE);
   assign gnt_o   = busy_o ? r_gnt : '0;
   assign done_o  = (r_state == STATE_DONE) ? r_gnt : '0;
   assign count_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_counter_load_sched.sv
// ============================================================================
// Module   : tb_counter_load_sched
// Purpose  : Directed self-checking bench for counter_load_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_load_sched;

   localparam int NUM_REQ = 4;

   logic                 clk;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_i;
   logic [4*NUM_REQ-1:0] load_val_i;
   logic [NUM_REQ-1:0]   gnt_o;
   logic [NUM_REQ-1:0]   done_o;
   logic                 busy_o;
   logic [3:0]           count_o;

   int n_checks = 0;
   int n_pass   = 0;

   counter_load_sched #(
      .NUM_REQ (NUM_REQ)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req_i),
      .load_val_i (load_val_i),
      .gnt_o      (gnt_o),
      .done_o     (done_o),
      .busy_o     (busy_o),
      .count_o    (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b0;
      req_i      = '0;
      load_val_i = '0;

      // Reset state
      tick(2);
      check("rst_gnt",   gnt_o,   0);
      check("rst_done",  done_o,  0);
      check("rst_busy",  busy_o,  0);
      check("rst_count", count_o, 0);
      reset = 1'b1;
      tick(1);
      check("idle_busy", busy_o, 0);

      // Requester 0, load C: grant after edge 1, count C..F, done after edge 6
      req_i      = 4'b0001;
      load_val_i = 16'h000C;
      tick(1);
      check("r0_gnt",  gnt_o,  4'b0001);
      check("r0_busy", busy_o, 1);
      tick(1);
      check("r0_cnt_c", count_o, 4'hC);
      tick(1);
      check("r0_cnt_d", count_o, 4'hD);
      tick(1);
      check("r0_cnt_e", count_o, 4'hE);
      tick(1);
      check("r0_cnt_f", count_o, 4'hF);
      check("r0_nodone", done_o, 0);
      tick(1);
      check("r0_done",  done_o,  4'b0001);
      check("r0_hold",  count_o, 4'hF);
      req_i = '0;
      tick(1);
      check("r0_idle_gnt",  gnt_o,   0);
      check("r0_idle_done", done_o,  0);
      check("r0_idle_cnt",  count_o, 4'hF);

      // Requester 1 load 5, reset asserted with count 7
      req_i      = 4'b0010;
      load_val_i = 16'h0050;
      tick(1);
      check("r1_gnt", gnt_o, 4'b0010);
      tick(3);
      check("r1_cnt7", count_o, 4'h7);
      reset = 1'b0;
      #1;
      check("arst_gnt",   gnt_o,   0);
      check("arst_done",  done_o,  0);
      check("arst_busy",  busy_o,  0);
      check("arst_count", count_o, 0);
      req_i = '0;
      tick(2);
      check("arst_nodone", done_o, 0);
      reset = 1'b1;
      tick(1);

      // All requesting, loads F: grants 0,1,2,3,0 every 4 cycles
      req_i      = 4'b1111;
      load_val_i = 16'hFFFF;
      tick(1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rr_gnt%0d", i), gnt_o, 32'(1 << (i % 4)));
         tick(2);
         check($sformatf("rr_done%0d", i), done_o, 32'(1 << (i % 4)));
         tick(2);
      end
      check("rr_gnt_next", gnt_o, 4'b0010);
      req_i = '0;
      tick(5);
      check("rr_idle", busy_o, 0);

      // Requester 2 load 0: counts 0..F, done after edge 18, no wrap
      req_i      = 4'b0100;
      load_val_i = 16'h0000;
      tick(1);
      check("r2_gnt", gnt_o, 4'b0100);
      tick(1);
      check("r2_cnt0", count_o, 4'h0);
      tick(15);
      check("r2_cnt_f",  count_o, 4'hF);
      check("r2_nodone", done_o,  0);
      tick(1);
      check("r2_done", done_o, 4'b0100);
      req_i = '0;
      tick(4);
      check("r2_nowrap", count_o, 4'hF);
      check("r2_idle",   busy_o,  0);

      // Requester 3 granted next; drop its request during COUNT
      req_i      = 4'b1000;
      load_val_i = 16'h0000;
      tick(1);
      check("r3_gnt", gnt_o, 4'b1000);
      tick(2);
      check("r3_cnt1", count_o, 4'h1);
      req_i = 4'b0011;
`ifdef COUNTER_LOAD_SCHED_ABORT_EN
      tick(1);
      check("ab_busy", busy_o,  0);
      check("ab_done", done_o,  0);
      check("ab_cnt",  count_o, 4'h1);
      tick(1);
      check("ab_next_gnt", gnt_o, 4'b0001);
`else
      tick(14);
      check("na_gnt_held", gnt_o,   4'b1000);
      check("na_cnt_f",    count_o, 4'hF);
      check("na_nodone",   done_o,  0);
      tick(1);
      check("na_done", done_o, 4'b1000);
      tick(2);
      check("na_next_gnt", gnt_o, 4'b0001);
`endif
      req_i = '0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
